// File: rtl/fetch_controller.sv
// Instruction fetch controller: IDLE/FETCH/DELIVER sequencer with
// branch/jump/register redirect and a retired-instruction counter.
module fetch_controller #(
    parameter logic [31:0] RESET_PC = 32'h00000000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [1:0]  redirect_kind,
    input  logic [15:0] branch_offset,
    input  logic [25:0] jump_target,
    input  logic [31:0] reg_target,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic [31:0] retired
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        DELIVER = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_fetch_pc;
    logic [31:0] r_instr;
    logic [31:0] r_instr_pc;
    logic [31:0] r_retired;
    logic        r_imem_req;
    logic        r_instr_valid;
    logic        w_accept;
    logic        w_capture;
    logic [31:0] w_p1;
    logic [31:0] w_next_pc;

    // Next-state decode plus acceptance/capture strobes
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (en)
                    w_next_state = FETCH;
            end
            FETCH: begin
                if (imem_ready) begin
                    w_capture    = 1'b1;
                    w_next_state = DELIVER;
                end
            end
            DELIVER: begin
                if (!stall) begin
                    w_accept     = 1'b1;
                    w_next_state = en ? FETCH : IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Next fetch address from the instruction being accepted
    always_comb begin
        w_p1      = r_instr_pc + 32'd1;
        w_next_pc = w_p1;
        if (redirect_valid) begin
            case (redirect_kind)
                2'b01:   w_next_pc = w_p1 + {{16{branch_offset[15]}}, branch_offset};
                2'b10:   w_next_pc = {w_p1[31:26], jump_target};
                2'b11:   w_next_pc = reg_target;
                default: w_next_pc = w_p1;
            endcase
        end
    end

    // State, datapath and registered outputs; reset wins over everything
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= IDLE;
            r_fetch_pc    <= RESET_PC;
            r_instr       <= 32'd0;
            r_instr_pc    <= 32'd0;
            r_retired     <= 32'd0;
            r_imem_req    <= 1'b0;
            r_instr_valid <= 1'b0;
        end else begin
            r_state       <= w_next_state;
            r_imem_req    <= (w_next_state == FETCH);
            r_instr_valid <= (w_next_state == DELIVER);
            if (w_capture) begin
                r_instr    <= imem_rdata;
                r_instr_pc <= r_fetch_pc;
            end
            if (w_accept) begin
                r_retired  <= r_retired + 32'd1;
                r_fetch_pc <= w_next_pc;
            end
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_fetch_pc;
    assign instr_valid = r_instr_valid;
    assign instr       = r_instr;
    assign instr_pc    = r_instr_pc;
    assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_controller.sv
// Self-checking bench for fetch_controller: redirect vector table,
// fetch scoreboard, stall, reset-in-flight and en-drop sequences.
module tb_fetch_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        stall;
    logic        redirect_valid;
    logic [1:0]  redirect_kind;
    logic [15:0] branch_offset;
    logic [25:0] jump_target;
    logic [31:0] reg_target;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic [31:0] retired;

    fetch_controller dut (
        .clk            (clk),
        .reset          (reset),
        .en             (en),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_kind  (redirect_kind),
        .branch_offset  (branch_offset),
        .jump_target    (jump_target),
        .reg_target     (reg_target),
        .imem_ready     (imem_ready),
        .imem_rdata     (imem_rdata),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .retired        (retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } fetch_t;

    typedef struct {
        logic [31:0] pc;
        logic        rv;
        logic [1:0]  kind;
        logic [15:0] off;
        logic [25:0] jt;
        logic [31:0] rt;
        logic [31:0] exp_addr;
    } vec_t;

    fetch_t      sb[$];
    vec_t        vecs[8];
    int          total = 0;
    int          bad = 0;
    logic [31:0] cur;
    logic [31:0] ret_model;
    logic [31:0] held;

    function automatic logic [31:0] dat(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h00001234;
    endfunction

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch_one(input logic [31:0] a);
        fetch_t f;
        fetch_t g;
        int     n;
        n = 0;
        while (!imem_req && n < 10) begin
            cycle();
            n++;
        end
        check("req_wait", {31'd0, imem_req}, 32'd1);
        if (!imem_req) return;
        check("fetch_addr", imem_addr, a);
        f.addr = a;
        f.data = dat(a);
        sb.push_back(f);
        imem_ready = 1'b1;
        imem_rdata = f.data;
        cycle();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        check("deliver_valid", {31'd0, instr_valid}, 32'd1);
        check("deliver_req", {31'd0, imem_req}, 32'd0);
        g = sb.pop_front();
        check("instr", instr, g.data);
        check("instr_pc", instr_pc, g.addr);
    endtask

    task automatic accept(input logic rv, input logic [1:0] kind,
                          input logic [15:0] off, input logic [25:0] jt,
                          input logic [31:0] rt);
        stall          = 1'b0;
        redirect_valid = rv;
        redirect_kind  = kind;
        branch_offset  = off;
        jump_target    = jt;
        reg_target     = rt;
        cycle();
        redirect_valid = 1'b0;
        ret_model      = ret_model + 32'd1;
        check("retired", retired, ret_model);
        check("accept_req", {31'd0, imem_req}, {31'd0, en});
        check("accept_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic goto_pc(input logic [31:0] pc);
        fetch_one(cur);
        accept(1'b1, 2'b11, 16'd0, 26'd0, pc);
        check("goto_addr", imem_addr, pc);
        cur = pc;
    endtask

    initial begin
        vecs[0] = '{32'd10, 1'b1, 2'b01, 16'hFFFC, 26'd0, 32'd0, 32'd7};
        vecs[1] = '{32'd10, 1'b1, 2'b01, 16'h0005, 26'd0, 32'd0, 32'd16};
        vecs[2] = '{32'h0400_0002, 1'b1, 2'b10, 16'd0, 26'h0000010, 32'd0,
                    32'h0400_0010};
        vecs[3] = '{32'h0400_0002, 1'b1, 2'b11, 16'd0, 26'd0, 32'h100,
                    32'h100};
        vecs[4] = '{32'hFFFF_FFFF, 1'b1, 2'b00, 16'h0007, 26'd5, 32'h55,
                    32'd0};
        vecs[5] = '{32'd20, 1'b0, 2'b01, 16'h0005, 26'd0, 32'd0, 32'd21};
        vecs[6] = '{32'hFFFF_FFFF, 1'b1, 2'b01, 16'h0001, 26'd0, 32'd0,
                    32'd1};
        vecs[7] = '{32'hFC00_0005, 1'b1, 2'b10, 16'd0, 26'h3FF_FFFF, 32'd0,
                    32'hFFFF_FFFF};

        reset          = 1'b1;
        en             = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_kind  = 2'b00;
        branch_offset  = 16'd0;
        jump_target    = 26'd0;
        reg_target     = 32'd0;
        imem_ready     = 1'b0;
        imem_rdata     = 32'd0;
        ret_model      = 32'd0;
        cycle();
        cycle();
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_pc", instr_pc, 32'd0);
        check("rst_retired", retired, 32'd0);
        check("rst_addr", imem_addr, 32'd0);

        reset = 1'b0;
        en    = 1'b1;
        cycle();
        check("idle_to_fetch", {31'd0, imem_req}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            fetch_one(32'(i));
            accept(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        end
        check("retired4", retired, 32'd4);
        cur = 32'd4;

        for (int i = 0; i < 8; i++) begin
            goto_pc(vecs[i].pc);
            fetch_one(vecs[i].pc);
            accept(vecs[i].rv, vecs[i].kind, vecs[i].off, vecs[i].jt,
                   vecs[i].rt);
            check($sformatf("vec%0d_addr", i), imem_addr, vecs[i].exp_addr);
            cur = vecs[i].exp_addr;
        end

        goto_pc(32'd5);
        fetch_one(32'd5);
        held           = instr;
        stall          = 1'b1;
        redirect_valid = 1'b1;
        redirect_kind  = 2'b11;
        reg_target     = 32'h777;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("stall_valid", {31'd0, instr_valid}, 32'd1);
            check("stall_instr", instr, held);
            check("stall_pc", instr_pc, 32'd5);
            check("stall_req", {31'd0, imem_req}, 32'd0);
            check("stall_retired", retired, ret_model);
        end
        accept(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        check("stall_next", imem_addr, 32'd6);

        imem_ready = 1'b0;
        check("wait_req1", {31'd0, imem_req}, 32'd1);
        check("wait_addr1", imem_addr, 32'd6);
        cycle();
        check("wait_req2", {31'd0, imem_req}, 32'd1);
        check("wait_addr2", imem_addr, 32'd6);
        reset      = 1'b1;
        imem_ready = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        cycle();
        reset      = 1'b0;
        imem_ready = 1'b0;
        ret_model  = 32'd0;
        check("mid_rst_req", {31'd0, imem_req}, 32'd0);
        check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
        check("mid_rst_addr", imem_addr, 32'd0);
        check("mid_rst_instr", instr, 32'd0);
        check("mid_rst_ret", retired, 32'd0);
        cycle();
        check("post_rst_req", {31'd0, imem_req}, 32'd1);
        check("post_rst_addr", imem_addr, 32'd0);
        cur = 32'd0;

        goto_pc(32'hFFFF_FFFF);
        fetch_one(32'hFFFF_FFFF);
        en = 1'b0;
        accept(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        check("wrap_addr", imem_addr, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("idle_req", {31'd0, imem_req}, 32'd0);
            check("idle_valid", {31'd0, instr_valid}, 32'd0);
        end
        en = 1'b1;
        cycle();
        check("resume_req", {31'd0, imem_req}, 32'd1);
        check("resume_addr", imem_addr, 32'd0);

        en = 1'b0;
        cycle();
        check("en_drop_req", {31'd0, imem_req}, 32'd1);
        fetch_one(32'd0);
        accept(1'b0, 2'b00, 16'd0, 26'd0, 32'd0);
        check("en_drop_addr", imem_addr, 32'd1);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule

// File: doc/fetch_controller.md
FETCH_CONTROLLER -- requirements
Module: fetch_controller

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000: fetch address loaded on reset.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-004 en  input  1  fetch enable; low means no new fetch starts.
REQ-005 stall  input  1  consumer back-pressure; delivered instruction is held while high.
REQ-006 redirect_valid  input  1  control-flow change request, sampled only with an accepted instruction.
REQ-007 redirect_kind  input  2  01 branch, 10 jump, 11 register, 00 none (treated as sequential).
REQ-008 branch_offset  input  16  signed word offset for branch.
REQ-009 jump_target  input  26  word target for jump.
REQ-010 reg_target  input  32  full word target for register jump.
REQ-011 imem_ready  input  1  memory accepts request and returns data in the same cycle.
REQ-012 imem_rdata  input  32  instruction word, valid when imem_ready is high.
REQ-013 imem_req  output  1  fetch request to instruction memory.
REQ-014 imem_addr  output  32  word address of the request.
REQ-015 instr_valid  output  1  instr/instr_pc hold a deliverable instruction.
REQ-016 instr  output  32  delivered instruction word.
REQ-017 instr_pc  output  32  word address of the delivered instruction.
REQ-018 retired  output  32  count of accepted instructions, wraps at 2^32.

Function
REQ-019 FSM states IDLE, FETCH, DELIVER; registered outputs only.
REQ-020 IDLE: imem_req=0, instr_valid=0; en=1 -> FETCH next cycle.
REQ-021 FETCH: imem_req=1, imem_addr=fetch_pc; imem_ready=1 -> capture imem_rdata into instr, fetch_pc into instr_pc, go DELIVER; imem_ready=0 -> stay, address held stable.
REQ-022 DELIVER: instr_valid=1, imem_req=0; acceptance = instr_valid & !stall.
REQ-023 On acceptance: retired increments by 1; fetch_pc loaded with next PC; go FETCH if en=1, else IDLE.
REQ-024 Next PC (word addressing, p1 = instr_pc + 1): none/00 -> p1; branch -> p1 + sign-extended branch_offset (mod 2^32); jump -> {p1[31:26], jump_target}; register -> reg_target.
REQ-025 redirect_valid ignored when not accepting (stalled or not DELIVER).
REQ-026 While stall=1 in DELIVER: instr, instr_pc, instr_valid unchanged; no memory request.
REQ-027 en dropping during FETCH does not abort the request; the fetched instruction is still delivered.
REQ-028 Latency: acceptance at cycle N -> imem_req high at N+1; imem_ready at M -> instr_valid high at M+1.
REQ-029 fetch_pc and all arithmetic wrap modulo 2^32; 32'hFFFFFFFF + 1 = 0.

Reset
REQ-030 reset=1 at any posedge, any state: state=IDLE, fetch_pc=RESET_PC, imem_req=0, instr_valid=0, instr=0, instr_pc=0, retired=0, effective next cycle.
REQ-031 reset overrides en, stall, redirect and imem_ready in the same cycle; a request in flight is abandoned and its data discarded.

Verification
REQ-032 Reset, en=1, imem_ready=1, stall=0 -> addresses 0,1,2,3 requested on alternate cycles; instr_pc 0,1,2,3; retired=4.
REQ-033 Stall=1 for 3 cycles on instr at pc 5 -> instr_valid held, instr/instr_pc stable, imem_req=0, retired unchanged until release.
REQ-034 Accept instr_pc=10 with branch, offset 16'hFFFC -> next imem_addr=7; offset 16'h0005 -> next imem_addr=16.
REQ-035 Accept instr_pc=32'h0400_0002 with jump, target 26'h0000010 -> next imem_addr=32'h0400_0010; register kind with reg_target=32'h100 -> next imem_addr=32'h100.
REQ-036 imem_ready low 4 cycles in FETCH -> imem_req and imem_addr stable; reset asserted in cycle 2 -> next cycle IDLE, imem_req=0, fetch_pc=RESET_PC.
REQ-037 Accept instr_pc=32'hFFFFFFFF sequentially -> next imem_addr=0; en=0 at acceptance -> IDLE, no further requests.
